// File: rtl/mycpu_pkg.sv
// Shared types for the fetch-stage program counter: PC select encoding and default RAS depth.
package mycpu_pkg;

    typedef enum logic [2:0] {
        PC_INC_S   = 3'b000,
        PC_JUMP    = 3'b001,
        PC_RET_EXT = 3'b010,
        PC_BRANCH  = 3'b011,
        PC_CALL    = 3'b100,
        PC_RET     = 3'b101,
        PC_HOLD0   = 3'b110,
        PC_HOLD1   = 3'b111
    } pc_sel_t;

    localparam int PC_RAS_DEPTH_DEF = 4;

endpackage

// File: rtl/pc_ras_unit_ras_stack.sv
// Circular LIFO of return addresses; state updates on the enabled clock edge, top is combinational.
// Pushing when full overwrites the oldest entry; popping when empty leaves state untouched.
module ras_stack #(
    parameter int DW        = 16,
    parameter int RAS_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en_in,
    input  logic                       push_in,
    input  logic                       pop_in,
    input  logic [DW-1:0]              push_dat_in,
    output logic [DW-1:0]              top_out,
    output logic                       empty_out,
    output logic                       full_out,
    output logic                       ovf_out,
    output logic                       unf_out,
    output logic [$clog2(RAS_DEPTH):0] cnt_out
);

    localparam int AW = $clog2(RAS_DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW:0]   CNT_MAX = (AW+1)'(RAS_DEPTH);

    logic [DW-1:0] mem_q [RAS_DEPTH];
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW:0]   cnt_q, cnt_d;

    // ptr_q points at the next free slot; the newest entry sits just below it.
    assign empty_out = (cnt_q == '0);
    assign full_out  = (cnt_q == CNT_MAX);
    assign top_out   = mem_q[ptr_q - PTR_ONE];
    assign ovf_out   = en_in & push_in & full_out;
    assign unf_out   = en_in & pop_in & empty_out;
    assign cnt_out   = cnt_q;

    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (push_in) begin
            ptr_d = ptr_q + PTR_ONE;
            if (!full_out) cnt_d = cnt_q + CNT_ONE;
        end else if (pop_in && !empty_out) begin
            ptr_d = ptr_q - PTR_ONE;
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else if (en_in) begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && en_in && push_in) mem_q[ptr_q] <= push_dat_in;
    end

endmodule

// File: rtl/pc_ras_unit_sva.sv
// Protocol checks bound into pc_ras_unit: underflow flagging, RAS occupancy bound, stall stability.
module pc_ras_unit_sva
    import mycpu_pkg::*;
#(
    parameter int DW        = 16,
    parameter int RAS_DEPTH = 4
) (
    input logic                       clk,
    input logic                       rst_n,
    input logic                       en_in,
    input logic [2:0]                 ps_in,
    input logic [DW-1:0]              pc_out,
    input logic                       ras_empty_out,
    input logic                       ras_err_out,
    input logic [$clog2(RAS_DEPTH):0] ras_cnt
);

    localparam logic [$clog2(RAS_DEPTH):0] CNT_MAX = ($clog2(RAS_DEPTH)+1)'(RAS_DEPTH);

    a_pop_empty_flags: assert property (@(posedge clk) disable iff (!rst_n)
        (en_in && ps_in == PC_RET && ras_empty_out) |=> ras_err_out);

    a_cnt_bound: assert property (@(posedge clk) disable iff (!rst_n)
        ras_cnt <= CNT_MAX);

    a_stall_stable: assert property (@(posedge clk)
        (rst_n && !en_in) |=> $stable(pc_out));

endmodule

bind pc_ras_unit pc_ras_unit_sva #(.DW(DW), .RAS_DEPTH(RAS_DEPTH)) u_sva (
    .clk           (clk),
    .rst_n         (rst_n),
    .en_in         (en_in),
    .ps_in         (ps_in),
    .pc_out        (pc_out),
    .ras_empty_out (ras_empty_out),
    .ras_err_out   (ras_err_out),
    .ras_cnt       (ras_cnt)
);

// File: rtl/pc_ras_unit.sv
// Fetch-stage program counter with return-address stack; new PC visible one cycle after the sampling edge.
// en_in=0 stalls every register; there is no other backpressure.
module pc_ras_unit
    import mycpu_pkg::*;
#(
    parameter int          DW        = 16,
    parameter int          RAS_DEPTH = PC_RAS_DEPTH_DEF,
    parameter logic [DW-1:0] RESET_VEC = '0,
    parameter int          PC_INC    = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en_in,
    input  logic [2:0]    ps_in,
    input  logic [DW-1:0] ia_in,
    input  logic [DW-1:0] ra_in,
    output logic [DW-1:0] pc_out,
    output logic          ras_empty_out,
    output logic          ras_full_out,
    output logic          ras_err_out
);

    localparam logic [DW-1:0] INC_C = DW'(PC_INC);

    pc_sel_t       sel;
    logic [DW-1:0] pc_q, pc_d;
    logic          err_q, err_d;
    logic          push, pop;
    logic [DW-1:0] ras_top;
    logic          ras_ovf, ras_unf;
    logic [$clog2(RAS_DEPTH):0] ras_cnt;

    assign sel = pc_sel_t'(ps_in);

    ras_stack #(.DW(DW), .RAS_DEPTH(RAS_DEPTH)) u_ras (
        .clk         (clk),
        .rst_n       (rst_n),
        .en_in       (en_in),
        .push_in     (push),
        .pop_in      (pop),
        .push_dat_in (pc_q + INC_C),
        .top_out     (ras_top),
        .empty_out   (ras_empty_out),
        .full_out    (ras_full_out),
        .ovf_out     (ras_ovf),
        .unf_out     (ras_unf),
        .cnt_out     (ras_cnt)
    );

    always_comb begin
        pc_d = pc_q;
        push = 1'b0;
        pop  = 1'b0;
        case (sel)
            PC_INC_S:   pc_d = pc_q + INC_C;
            PC_JUMP:    pc_d = ia_in;
            PC_RET_EXT: pc_d = ra_in;
            // Two's complement offset: a modular add covers negative offsets.
            PC_BRANCH:  pc_d = pc_q + ia_in;
            PC_CALL: begin
                pc_d = ia_in;
                push = 1'b1;
            end
            PC_RET: begin
                pop  = 1'b1;
                pc_d = ras_empty_out ? ra_in : ras_top;
            end
            default:    pc_d = pc_q;
        endcase
        err_d = err_q | ras_ovf | ras_unf;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q  <= RESET_VEC;
            err_q <= 1'b0;
        end else if (en_in) begin
            pc_q  <= pc_d;
            err_q <= err_d;
        end
    end

    assign pc_out      = pc_q;
    assign ras_err_out = err_q;

endmodule

// File: tb/tb_pc_ras_unit.sv
// Scoreboard bench for pc_ras_unit: directed scenarios plus random traffic against a queue-based model.
module tb_pc_ras_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en_in = 1'b0;
    logic [2:0]  ps_in = 3'b000;
    logic [15:0] ia_in = '0;
    logic [15:0] ra_in = '0;
    logic [15:0] pc_out;
    logic        ras_empty_out, ras_full_out, ras_err_out;

    pc_ras_unit #(.DW(16), .RAS_DEPTH(DEPTH), .RESET_VEC(16'h0000), .PC_INC(1)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en_in         (en_in),
        .ps_in         (ps_in),
        .ia_in         (ia_in),
        .ra_in         (ra_in),
        .pc_out        (pc_out),
        .ras_empty_out (ras_empty_out),
        .ras_full_out  (ras_full_out),
        .ras_err_out   (ras_err_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pc;
        logic        empty;
        logic        full;
        logic        err;
        string       tag;
    } exp_t;

    exp_t        sb_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    // Reference model: the RAS is a plain queue, newest at the back.
    logic [15:0] m_pc = 16'h0000;
    logic [15:0] m_ras[$];
    logic        m_err = 1'b0;

    function automatic void check(string name, logic [15:0] act, logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
        end
    endfunction

    task automatic step(input logic rst, input logic en, input logic [2:0] sel,
                        input logic [15:0] ia, input logic [15:0] ra, input string tag);
        exp_t e;
        @(negedge clk);
        rst_n = ~rst;
        en_in = en;
        ps_in = sel;
        ia_in = ia;
        ra_in = ra;
        if (rst) begin
            m_pc  = 16'h0000;
            m_err = 1'b0;
            m_ras.delete();
        end else if (en) begin
            case (sel)
                3'd0: m_pc = m_pc + 16'd1;
                3'd1: m_pc = ia;
                3'd2: m_pc = ra;
                3'd3: m_pc = 16'(int'(m_pc) + int'($signed(ia)));
                3'd4: begin
                    m_ras.push_back(m_pc + 16'd1);
                    if (m_ras.size() > DEPTH) begin
                        void'(m_ras.pop_front());
                        m_err = 1'b1;
                    end
                    m_pc = ia;
                end
                3'd5: begin
                    if (m_ras.size() == 0) begin
                        m_pc  = ra;
                        m_err = 1'b1;
                    end else begin
                        m_pc = m_ras.pop_back();
                    end
                end
                default: ;
            endcase
        end
        e.pc    = m_pc;
        e.empty = (m_ras.size() == 0);
        e.full  = (m_ras.size() == DEPTH);
        e.err   = m_err;
        e.tag   = tag;
        sb_q.push_back(e);
        @(posedge clk);
    endtask

    // Monitor: every edge the DUT presents a new registered state.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() != 0) begin
                exp_t e;
                e = sb_q.pop_front();
                check({e.tag, ".pc"},    pc_out,               e.pc);
                check({e.tag, ".empty"}, {15'b0, ras_empty_out}, {15'b0, e.empty});
                check({e.tag, ".full"},  {15'b0, ras_full_out},  {15'b0, e.full});
                check({e.tag, ".err"},   {15'b0, ras_err_out},   {15'b0, e.err});
            end
        end
    end

    initial begin
        int drain;
        // 1: reset, increments, mid-run reset
        step(1, 0, 3'd0, 16'h0, 16'h0, "reset");
        step(1, 1, 3'd4, 16'h7777, 16'h0, "reset_call");
        repeat (3) step(0, 1, 3'd0, 16'h0, 16'h0, "inc");
        step(1, 1, 3'd0, 16'h0, 16'h0, "mid_reset");
        // 2: nested call/return
        step(0, 1, 3'd1, 16'h0010, 16'h0, "jump10");
        step(0, 1, 3'd4, 16'h0100, 16'h0, "call100");
        step(0, 1, 3'd4, 16'h0200, 16'h0, "call200");
        step(0, 1, 3'd5, 16'h0, 16'h0, "ret1");
        step(0, 1, 3'd5, 16'h0, 16'h0, "ret2");
        // 3: branch and wrap
        step(0, 1, 3'd1, 16'h0050, 16'h0, "jump50");
        step(0, 1, 3'd3, 16'hFFF0, 16'h0, "branch_neg");
        step(0, 1, 3'd1, 16'hFFFF, 16'h0, "jumpffff");
        step(0, 1, 3'd0, 16'h0, 16'h0, "inc_wrap");
        step(0, 1, 3'd1, 16'hFFFE, 16'h0, "jumpfffe");
        step(0, 1, 3'd3, 16'h0004, 16'h0, "branch_wrap");
        // 4: overflow then underflow
        step(1, 1, 3'd0, 16'h0, 16'h0, "reset4");
        for (int i = 1; i <= 5; i++) step(0, 1, 3'd4, 16'(i * 16'h0100), 16'h0, "call_fill");
        for (int i = 0; i < 4; i++)  step(0, 1, 3'd5, 16'h0, 16'h0, "ret_drain");
        step(0, 1, 3'd5, 16'h0, 16'hBEEF, "ret_under");
        // 5: stall
        step(1, 1, 3'd0, 16'h0, 16'h0, "reset5");
        step(0, 1, 3'd4, 16'h0040, 16'h0, "call_pre");
        repeat (3) step(0, 0, 3'd4, 16'h1234, 16'h0, "stall");
        step(0, 1, 3'd4, 16'h1234, 16'h0, "unstall");
        // 6: underflow after reset, hold codes
        step(1, 1, 3'd0, 16'h0, 16'h0, "reset6");
        step(0, 1, 3'd5, 16'h0, 16'h0ABC, "ret_empty");
        step(0, 1, 3'd6, 16'h5555, 16'h6666, "hold6");
        step(0, 1, 3'd7, 16'h5555, 16'h6666, "hold7");
        // random traffic
        step(1, 1, 3'd0, 16'h0, 16'h0, "reset_rand");
        for (int i = 0; i < 400; i++) begin
            logic rst, en;
            logic [2:0] sel;
            rst = ($urandom_range(0, 49) == 0);
            en  = ($urandom_range(0, 4) != 0);
            sel = 3'($urandom_range(0, 7));
            step(rst, en, sel, 16'($urandom), 16'($urandom), "rand");
        end
        drain = 0;
        while (sb_q.size() != 0 && drain < 10) begin
            @(posedge clk);
            drain++;
        end
        #2;
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
